// File: rtl/data_bus_responder.sv
// Single-cycle RAM + MMIO data-bus responder with TOHOST halt, cycle counter and sticky fault flag.
// Define DATA_BUS_RESPONDER_CYCLE_COUNTER_EN to build the 64-bit cycle counter and its high-word shadow.
module data_bus_responder #(
    parameter int unsigned RAM_WORDS_LOG2 = 10,
    parameter logic [31:0] RAM_BASE       = 32'h8000_0000,
    parameter logic [31:0] MMIO_BASE      = 32'hC000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [3:0]  bus_byte_enable,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_read_data,
    output logic        halted,
    output logic [31:0] exit_code,
    output logic        bus_error
);

    localparam int unsigned RAM_WORDS = 1 << RAM_WORDS_LOG2;
    localparam int unsigned IDX_MSB   = RAM_WORDS_LOG2 + 1;
    localparam int unsigned TAG_LSB   = RAM_WORDS_LOG2 + 2;

    typedef enum logic [1:0] {
        REG_TOHOST   = 2'd0,
        REG_CYCLE_LO = 2'd1,
        REG_CYCLE_HI = 2'd2,
        REG_STATUS   = 2'd3
    } mmio_reg_e;

    logic [31:0] mem_q [RAM_WORDS];

    logic        halted_q, halted_d;
    logic [31:0] exit_code_q, exit_code_d;
    logic        bus_error_q, bus_error_d;

`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
    logic [63:0] cycle_q, cycle_d;
    logic [31:0] cycle_hi_shadow_q, cycle_hi_shadow_d;
`endif

    logic                      ram_hit;
    logic                      mmio_sel;
    logic                      fault;
    logic                      rd_active;
    logic                      wr_active;
    logic [RAM_WORDS_LOG2-1:0] ram_index;
    mmio_reg_e                 mmio_reg;
    logic [3:0]                ram_lane_we;
    logic                      unused_addr_lsbs;

    always_comb begin
        unused_addr_lsbs = ^bus_address[1:0];
        ram_hit   = (bus_address[31:TAG_LSB] == RAM_BASE[31:TAG_LSB]);
        // RAM decode wins should the two windows ever be configured to overlap
        mmio_sel  = (bus_address[31:4] == MMIO_BASE[31:4]) && !ram_hit;
        ram_index = bus_address[IDX_MSB:2];
        mmio_reg  = mmio_reg_e'(bus_address[3:2]);
        fault     = (bus_read_enable && bus_write_enable) ||
                    ((bus_read_enable || bus_write_enable) && !ram_hit && !mmio_sel);
        rd_active = bus_read_enable && !fault;
        wr_active = bus_write_enable && !fault && !halted_q && !reset;
        ram_lane_we = (wr_active && ram_hit) ? bus_byte_enable : 4'b0000;
    end

    always_comb begin
        bus_read_data = '0;
        if (rd_active) begin
            if (ram_hit) begin
                bus_read_data = mem_q[ram_index];
            end else begin
                unique case (mmio_reg)
                    REG_TOHOST:   bus_read_data = exit_code_q;
`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
                    REG_CYCLE_LO: bus_read_data = cycle_q[31:0];
                    REG_CYCLE_HI: bus_read_data = cycle_hi_shadow_q;
`else
                    REG_CYCLE_LO: bus_read_data = '0;
                    REG_CYCLE_HI: bus_read_data = '0;
`endif
                    REG_STATUS:   bus_read_data = {30'b0, bus_error_q, halted_q};
                    default:      bus_read_data = '0;
                endcase
            end
        end
    end

    always_comb begin
        halted_d    = halted_q;
        exit_code_d = exit_code_q;
        bus_error_d = bus_error_q || fault;
        if (wr_active && mmio_sel && (mmio_reg == REG_TOHOST) && (bus_write_data != '0)) begin
            halted_d    = 1'b1;
            exit_code_d = bus_write_data;
        end
    end

`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
    always_comb begin
        cycle_d           = halted_q ? cycle_q : cycle_q + 64'd1;
        cycle_hi_shadow_d = cycle_hi_shadow_q;
        if (rd_active && mmio_sel && (mmio_reg == REG_CYCLE_LO)) begin
            cycle_hi_shadow_d = cycle_q[63:32];
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            halted_q          <= 1'b0;
            exit_code_q       <= '0;
            bus_error_q       <= 1'b0;
`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
            cycle_q           <= '0;
            cycle_hi_shadow_q <= '0;
`endif
        end else begin
            halted_q          <= halted_d;
            exit_code_q       <= exit_code_d;
            bus_error_q       <= bus_error_d;
`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
            cycle_q           <= cycle_d;
            cycle_hi_shadow_q <= cycle_hi_shadow_d;
`endif
        end
    end

    // RAM contents survive reset; wr_active already excludes reset cycles
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (ram_lane_we[i]) begin
                mem_q[ram_index][8*i +: 8] <= bus_write_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        halted    = halted_q;
        exit_code = exit_code_q;
        bus_error = bus_error_q;
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed vector table, corner sequences, and random traffic
// compared against an address-arithmetic reference model.
module tb_data_bus_responder;

    localparam logic [31:0] RB    = 32'h8000_0000;
    localparam logic [31:0] MB    = 32'hC000_0000;
    localparam int unsigned WORDS = 1024;
`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [31:0] bus_read_data;
    logic        halted;
    logic [31:0] exit_code;
    logic        bus_error;

    data_bus_responder #(
        .RAM_WORDS_LOG2(10),
        .RAM_BASE(RB),
        .MMIO_BASE(MB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus_address(bus_address),
        .bus_write_data(bus_write_data),
        .bus_byte_enable(bus_byte_enable),
        .bus_read_enable(bus_read_enable),
        .bus_write_enable(bus_write_enable),
        .bus_read_data(bus_read_data),
        .halted(halted),
        .exit_code(exit_code),
        .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0]     m_ram [WORDS];
    bit              m_halt;
    logic [31:0]     m_exit;
    bit              m_err;
    longint unsigned m_cyc;
    logic [31:0]     m_shadow;

    typedef struct {
        bit          rst;
        bit          re;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        bit          exp_halt;
        logic [31:0] exp_exit;
        bit          exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int region(input logic [31:0] a);
        if (a >= RB && (a - RB) < WORDS * 4) return 1;
        if (a >= MB && (a - MB) < 16) return 2;
        return 0;
    endfunction

    function automatic bit is_fault(input bit re, input bit we, input logic [31:0] a);
        return (re && we) || ((re || we) && region(a) == 0);
    endfunction

    function automatic logic [31:0] model_read(input bit re, input bit we, input logic [31:0] a);
        if (!re || is_fault(re, we, a)) return 32'h0;
        if (region(a) == 1) return m_ram[int'((a - RB) >> 2)];
        case (int'((a - MB) >> 2))
            0:       return m_exit;
            1:       return CNT_EN ? m_cyc[31:0] : 32'h0;
            2:       return CNT_EN ? m_shadow : 32'h0;
            default: return {30'b0, m_err, m_halt};
        endcase
    endfunction

    task automatic model_update(input bit rst, input bit re, input bit we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be);
        bit              old_halt;
        longint unsigned old_cyc;
        int              idx;
        if (rst) begin
            m_halt = 0; m_exit = 0; m_err = 0; m_cyc = 0; m_shadow = 0;
            return;
        end
        old_halt = m_halt;
        old_cyc  = m_cyc;
        if (is_fault(re, we, a)) begin
            m_err = 1;
        end else begin
            if (re && region(a) == 2 && ((a - MB) >> 2) == 1) m_shadow = old_cyc[63:32];
            if (we && !old_halt) begin
                if (region(a) == 1) begin
                    idx = int'((a - RB) >> 2);
                    for (int b = 0; b < 4; b++)
                        if (be[b]) m_ram[idx][8*b +: 8] = wd[8*b +: 8];
                end else if (((a - MB) >> 2) == 0 && wd != 0) begin
                    m_halt = 1;
                    m_exit = wd;
                end
            end
        end
        if (!old_halt) m_cyc = old_cyc + 1;
    endtask

    // One bus cycle: drive, sample read data mid-cycle, clock, update model, settle.
    task automatic step(input bit rst, input bit re, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output logic [31:0] mrd);
        reset            = rst;
        bus_read_enable  = re;
        bus_write_enable = we;
        bus_address      = a;
        bus_write_data   = wd;
        bus_byte_enable  = be;
        @(negedge clock);
        rd  = bus_read_data;
        mrd = model_read(re, we, a);
        @(posedge clock);
        model_update(rst, re, we, a, wd, be);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".halted"}, 64'(halted), 64'(m_halt));
        chk({tag, ".exit_code"}, 64'(exit_code), 64'(m_exit));
        chk({tag, ".bus_error"}, 64'(bus_error), 64'(m_err));
    endtask

    task automatic stepchk(input string tag, input bit rst, input bit re, input bit we,
                           input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] rd, mrd;
        step(rst, re, we, a, wd, be, rd, mrd);
        chk({tag, ".rdata"}, 64'(rd), 64'(mrd));
        chk_model(tag);
    endtask

    initial begin
        logic [31:0] rd, mrd;

        // Reset state
        step(1, 0, 0, 0, 0, 0, rd, mrd);
        chk("reset.halted", 64'(halted), 64'd0);
        chk("reset.exit_code", 64'(exit_code), 64'd0);
        chk("reset.bus_error", 64'(bus_error), 64'd0);

        // Give every RAM word a known value
        for (int i = 0; i < int'(WORDS); i++)
            step(0, 0, 1, RB + 32'(4 * i), 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000, 4'hF, rd, mrd);

        //               rst re we addr           wdata          be    exp_rd        halt exit  err
        tbl.push_back('{1, 0, 0, 32'h0,         32'h0,         4'h0, 32'h0,         0, 32'h0, 0});
        tbl.push_back('{0, 0, 1, 32'h8000_0010, 32'hAABB_CCDD, 4'hF, 32'h0,         0, 32'h0, 0});
        tbl.push_back('{0, 0, 1, 32'h8000_0010, 32'h0000_1100, 4'h2, 32'h0,         0, 32'h0, 0});
        tbl.push_back('{0, 1, 0, 32'h8000_0010, 32'h0,         4'h0, 32'hAABB_11DD, 0, 32'h0, 0});
        tbl.push_back('{0, 0, 1, 32'h8000_0000, 32'h1234_5678, 4'hF, 32'h0,         0, 32'h0, 0});
        tbl.push_back('{0, 0, 1, 32'h8000_0004, 32'h0BAD_F00D, 4'hF, 32'h0,         0, 32'h0, 0});
        tbl.push_back('{0, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 32'h0,         0, 32'h0, 0});
        tbl.push_back('{0, 1, 0, 32'h8000_0000, 32'h0,         4'h0, 32'h1234_5678, 0, 32'h0, 0});
        tbl.push_back('{0, 1, 0, 32'hC000_000C, 32'h0,         4'h0, 32'h0,         0, 32'h0, 0});
        tbl.push_back('{0, 0, 1, 32'hC000_0000, 32'h0,         4'hF, 32'h0,         0, 32'h0, 0});
        tbl.push_back('{0, 0, 1, 32'hC000_0004, 32'h5,         4'hF, 32'h0,         0, 32'h0, 0});
        tbl.push_back('{0, 1, 0, 32'h0000_1000, 32'h0,         4'h0, 32'h0,         0, 32'h0, 1});
        tbl.push_back('{0, 1, 1, 32'h8000_0000, 32'h0,         4'hF, 32'h0,         0, 32'h0, 1});
        tbl.push_back('{0, 1, 0, 32'h8000_0000, 32'h0,         4'h0, 32'h1234_5678, 0, 32'h0, 1});
        tbl.push_back('{0, 1, 0, 32'hC000_000C, 32'h0,         4'h0, 32'h2,         0, 32'h0, 1});
        tbl.push_back('{0, 1, 0, 32'h8000_1000, 32'h0,         4'h0, 32'h0,         0, 32'h0, 1});
        tbl.push_back('{0, 0, 1, 32'hC000_0000, 32'h1,         4'hF, 32'h0,         1, 32'h1, 1});
        tbl.push_back('{0, 0, 1, 32'h8000_0000, 32'h5,         4'hF, 32'h0,         1, 32'h1, 1});
        tbl.push_back('{0, 1, 0, 32'h8000_0000, 32'h0,         4'h0, 32'h1234_5678, 1, 32'h1, 1});
        tbl.push_back('{0, 1, 0, 32'hC000_000C, 32'h0,         4'h0, 32'h3,         1, 32'h1, 1});
        tbl.push_back('{0, 1, 0, 32'hC000_0000, 32'h0,         4'h0, 32'h1,         1, 32'h1, 1});
        tbl.push_back('{0, 0, 1, 32'hC000_0000, 32'h7,         4'hF, 32'h0,         1, 32'h1, 1});
        tbl.push_back('{1, 0, 1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0,         0, 32'h0, 0});
        tbl.push_back('{0, 1, 0, 32'h8000_0004, 32'h0,         4'h0, 32'h0BAD_F00D, 0, 32'h0, 0});
        tbl.push_back('{0, 1, 0, 32'h8000_0000, 32'h0,         4'h0, 32'h1234_5678, 0, 32'h0, 0});
        tbl.push_back('{0, 1, 0, 32'hC000_0004, 32'h0,         4'h0, CNT_EN ? 32'd2 : 32'd0, 0, 32'h0, 0});
        tbl.push_back('{0, 1, 0, 32'hC000_0008, 32'h0,         4'h0, 32'h0,         0, 32'h0, 0});
        tbl.push_back('{0, 1, 0, 32'hC000_000C, 32'h0,         4'h0, 32'h0,         0, 32'h0, 0});
        tbl.push_back('{1, 1, 0, 32'h8000_0010, 32'h0,         4'h0, 32'hAABB_11DD, 0, 32'h0, 0});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].re, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].be, rd, mrd);
            chk($sformatf("vec%0d.rdata", i), 64'(rd), 64'(tbl[i].exp_rd));
            chk($sformatf("vec%0d.halted", i), 64'(halted), 64'(tbl[i].exp_halt));
            chk($sformatf("vec%0d.exit_code", i), 64'(exit_code), 64'(tbl[i].exp_exit));
            chk($sformatf("vec%0d.bus_error", i), 64'(bus_error), 64'(tbl[i].exp_err));
        end

        // Reset while halted with a concurrent RAM write, then first post-reset cycle
        step(0, 0, 1, MB, 32'h3, 4'hF, rd, mrd);
        chk("halt3.halted", 64'(halted), 64'd1);
        chk("halt3.exit_code", 64'(exit_code), 64'd3);
        step(1, 0, 1, 32'h8000_0004, 32'h1111_1111, 4'hF, rd, mrd);
        chk("rsthalt.halted", 64'(halted), 64'd0);
        chk("rsthalt.exit_code", 64'(exit_code), 64'd0);
        step(0, 1, 0, MB + 4, 0, 0, rd, mrd);
        chk("post_rst.cycle_lo", 64'(rd), 64'd0);
        step(0, 1, 0, 32'h8000_0004, 0, 0, rd, mrd);
        chk("rsthalt.write_dropped", 64'(rd), 64'h0BAD_F00D);
        step(0, 1, 0, 32'h8000_0000, 0, 0, rd, mrd);
        chk("rsthalt.ram_kept", 64'(rd), 64'h1234_5678);
        chk("rsthalt.bus_error", 64'(bus_error), 64'd0);

        // Faults presented during reset are ignored
        step(1, 1, 0, 32'h0000_1000, 0, 0, rd, mrd);
        step(1, 1, 1, RB, 32'hFFFF_FFFF, 4'hF, rd, mrd);
        step(0, 0, 0, 0, 0, 0, rd, mrd);
        chk("rst_fault.bus_error", 64'(bus_error), 64'd0);

        // Faults still flagged while halted
        stepchk("halt9", 0, 0, 1, MB, 32'h9, 4'hF);
        step(0, 1, 0, MB + 16, 0, 0, rd, mrd);
        chk("halted_fault.rdata", 64'(rd), 64'd0);
        chk("halted_fault.bus_error", 64'(bus_error), 64'd1);
        chk("halted_fault.halted", 64'(halted), 64'd1);

        step(1, 0, 0, 0, 0, 0, rd, mrd);
`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
        // Snapshot of the high word at the CYCLE_LO read, then wrap
        force dut.cycle_q = 64'h0000_0001_FFFF_FFFF;
        #1;
        release dut.cycle_q;
        m_cyc = 64'h0000_0001_FFFF_FFFF;
        step(0, 1, 0, MB + 4, 0, 0, rd, mrd);
        chk("snap.cycle_lo", 64'(rd), 64'hFFFF_FFFF);
        step(0, 1, 0, MB + 8, 0, 0, rd, mrd);
        chk("snap.cycle_hi", 64'(rd), 64'h1);
        force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.cycle_q;
        m_cyc = 64'hFFFF_FFFF_FFFF_FFFF;
        step(0, 0, 0, 0, 0, 0, rd, mrd);
        step(0, 1, 0, MB + 4, 0, 0, rd, mrd);
        chk("wrap.cycle_lo", 64'(rd), 64'h0);
        step(0, 1, 0, MB + 8, 0, 0, rd, mrd);
        chk("wrap.cycle_hi", 64'(rd), 64'h0);
`else
        step(0, 1, 0, MB + 4, 0, 0, rd, mrd);
        chk("nocnt.cycle_lo", 64'(rd), 64'h0);
        step(0, 1, 0, MB + 8, 0, 0, rd, mrd);
        chk("nocnt.cycle_hi", 64'(rd), 64'h0);
        chk("nocnt.bus_error", 64'(bus_error), 64'd0);
`endif

        // Random traffic against the reference model
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] a, wd;
            logic [3:0]  be;
            bit          re, we, rst;
            int unsigned sel, op;
            sel = $urandom_range(0, 99);
            if (sel < 55)      a = RB + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            else if (sel < 60) a = RB + 32'd4092;
            else if (sel < 85) a = MB + 32'(4 * $urandom_range(0, 3));
            else if (sel < 89) a = RB + 32'd4096;
            else if (sel < 93) a = MB + 32'd16;
            else if (sel < 96) a = RB - 32'd4;
            else               a = $urandom();
            op = $urandom_range(0, 9);
            re = (op <= 3) || (op == 8);
            we = (op >= 4 && op <= 8);
            be = 4'($urandom_range(0, 15));
            wd = $urandom();
            if (region(a) == 2 && ((a - MB) >> 2) == 0 && $urandom_range(0, 15) != 0) wd = 32'h0;
            rst = ($urandom_range(0, 79) == 0);
            stepchk($sformatf("rand%0d", n), rst, re, we, a, wd, be);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
